xor_serial_unit: RTL and testbench
==================================

Name: xor_serial_unit

Overview:
- Multi-cycle, nibble-serial 32-bit XOR engine for the processor's multi-cycle datapath.
- Pairs with the single-cycle parallel XOR: that block computes in one combinational pass, this one accepts a start request, computes one 4-bit slice per cycle, and reports a registered result with a done pulse.
- The controller FSM drives it when the ALU path is time-shared.
- Its result must be bit-identical to the parallel XOR for all operands.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle.
- NSLICES, WIDTH/SLICE (8), derived local constant; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  32  operand A; captured on an accepted start.
- B  input  32  operand B; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when R has been updated.
- R  output  32  result register; holds its value until the next completion.

Behaviour:
- States:
  - IDLE: busy=0.
  - RUN: busy=1; slice counter cnt is 3 bits, 0..NSLICES-1.
- Reset (rst=1 at a clock edge): state=IDLE, cnt=0, operand regs=0, partial result=0, R=0, done=0, busy=0. Reset takes priority over all other inputs.
- IDLE, start=1 at edge k: capture A and B into operand regs, clear partial result, set cnt=0, go to RUN. busy=1 from cycle k+1.
- IDLE, start=0: hold state. R unchanged. done=0.
- RUN edge with cnt=i:
  - partial[SLICE*i+:SLICE] <= opA slice i XOR opB slice i (LSB slice first).
  - cnt <= i+1.
- Final RUN edge (cnt=NSLICES-1):
  - R <= full result including the last slice.
  - done <= 1; state <= IDLE; cnt <= 0.
- Latency: start accepted at edge k -> RUN for edges k+1..k+8 -> done=1 and R valid during the cycle after edge k+8. That is 8 busy cycles, then a done pulse.
- done is high for exactly one cycle; it is 0 in every other cycle.
- start while busy=1 is ignored, not queued, and has no effect on operands or result.
- start=1 in the cycle done=1 (state is IDLE) is accepted. Back-to-back operations therefore have a 9-cycle period, with R updating every 9 cycles.
- A and B may change freely after the accepting edge; only the captured copies are used.
- Reset mid-RUN aborts the operation: R returns to 0, no done pulse, next state IDLE.
- R never shows partial results. It changes only on the completion edge or on reset.
- Only 32-bit XOR; no carries, no sign handling.

Decomposition:
- Shared package/header:
  - state encoding constants: IDLE=1'b0, RUN=1'b1.
  - WIDTH, SLICE, NSLICES defaults.
- Sub-module: the existing 4-bit XOR slice (_4bit_xor), instantiated once. Its inputs are the slices of the captured operands selected by cnt.
- All sequential logic stays in this module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then idle 5 cycles -> R=0, busy=0, done=0 throughout.
- Basic op: A=0xFFFF0000, B=0x0F0F0F0F, start for 1 cycle -> busy=1 for 8 cycles, then done=1 for 1 cycle with R=0xF0F00F0F. Change A and B to 0 mid-run -> R unaffected.
- Ignored start: during RUN of A=0x12345678, B=0x87654321, assert start with A=B=0xFFFFFFFF -> R=0x95511559, and exactly one done pulse.
- Back-to-back: start held high continuously. A=0xAAAAAAAA, B=0x55555555 -> R=0xFFFFFFFF. Next op A=B=0xDEADBEEF -> R=0x00000000. done pulses 9 cycles apart.
- Reset mid-op: start with A=0xFFFFFFFF, B=0, rst=1 at the 4th RUN cycle -> R=0, busy=0 next cycle, no done pulse. A subsequent start completes normally with R=0xFFFFFFFF.
- Random: 1000 random A/B pairs -> each R equals A^B, computed against the parallel XOR model.

Source files
------------

// File: rtl/xor_serial_unit_pkg.sv
// Shared state encoding and default geometry for the nibble-serial XOR engine.
package xor_serial_unit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int WIDTH_DEF   = 32;
  localparam int SLICE_DEF   = 4;
  localparam int NSLICES_DEF = WIDTH_DEF / SLICE_DEF;

endpackage

// File: rtl/xor_serial_unit_4bit_xor.sv
// One combinational XOR slice; the serial engine reuses it once per cycle.
// Zero latency, no flow control.
module xor_serial_unit_4bit_xor #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/xor_serial_unit.sv
// Nibble-serial XOR: start accepted in IDLE, one slice per cycle, R + done pulse after NSLICES busy cycles.
// Start while busy is dropped (no queueing); back-to-back period is NSLICES+1 cycles.
module xor_serial_unit
  import xor_serial_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R
);

  localparam int NSLICES = WIDTH / SLICE;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   part_q;
  logic [WIDTH-1:0]   part_d;
  logic [WIDTH-1:0]   r_q;
  logic               done_q;
  logic               busy_q;

  logic [SLICE-1:0]   slice_a;
  logic [SLICE-1:0]   slice_b;
  logic [SLICE-1:0]   slice_y;

  assign slice_a = opa_q[SLICE*int'(cnt_q) +: SLICE];
  assign slice_b = opb_q[SLICE*int'(cnt_q) +: SLICE];

  xor_serial_unit_4bit_xor #(
    .W (SLICE)
  ) u_slice (
    .a_i (slice_a),
    .b_i (slice_b),
    .y_o (slice_y)
  );

  // Merged view lets the final edge publish the last slice without a bubble.
  always_comb begin
    part_d = part_q;
    part_d[SLICE*int'(cnt_q) +: SLICE] = slice_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      part_q  <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q   <= A;
            opb_q   <= B;
            part_q  <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          part_q <= part_d;
          if (cnt_q == LAST_CNT) begin
            r_q     <= part_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign R    = r_q;

endmodule

// File: tb/tb_xor_serial_unit.sv
// Directed bench for xor_serial_unit: vector table, multi-cycle corner sequences, random sweep.
module tb_xor_serial_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] R;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  xor_serial_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .R     (R)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge where done is seen (or after the budget).
  task automatic wait_done(input logic [31:0] r_prev, input string tag,
                           output int cyc, output int nbusy);
    logic r_moved;
    r_moved = 1'b0;
    cyc     = 0;
    nbusy   = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) nbusy++;
      if (R !== r_prev) r_moved = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({tag, " done seen"}, {31'b0, done}, 32'd1);
    check({tag, " R held during run"}, {31'b0, r_moved}, 32'd0);
    check({tag, " busy low at done"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input string tag);
    int cyc;
    int nb;
    logic [31:0] rp;
    rp    = R;
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A     = ~a;
    B     = ~b;
    wait_done(rp, tag, cyc, nb);
    check({tag, " busy cycles"}, 32'(nb), 32'd8);
    check({tag, " latency"}, 32'(cyc), 32'd8);
    check({tag, " R"}, R, exp_r);
    @(negedge clk);
    check({tag, " done one cycle"}, {31'b0, done}, 32'd0);
    check({tag, " R holds"}, R, exp_r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nb;
    int ndone;
    logic [31:0] rp;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, "basic"};
    vecs[1] = '{32'h00000000, 32'h00000000, 32'h00000000, "zeros"};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "ones"};
    vecs[3] = '{32'h80000001, 32'h00000001, 32'h80000000, "edge_bits"};
    vecs[4] = '{32'h0000000F, 32'h000000F0, 32'h000000FF, "low_slices"};
    vecs[5] = '{32'hF0000000, 32'h0F000000, 32'hFF000000, "top_slices"};
    vecs[6] = '{32'h13579BDF, 32'h2468ACE0, 32'h373F373F, "mixed"};
    vecs[7] = '{32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, "alt"};

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;

    repeat (2) begin
      @(negedge clk);
      check("reset R", R, 32'd0);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle R", R, 32'd0);
      check("idle busy", {31'b0, busy}, 32'd0);
      check("idle done", {31'b0, done}, 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].name);
    end

    // Start pulsed mid-run must be dropped.
    rp    = R;
    A     = 32'h12345678;
    B     = 32'h87654321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    A     = 32'hFFFFFFFF;
    B     = 32'hFFFFFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(rp, "ignored_start", cyc, nb);
    check("ignored_start remaining cycles", 32'(cyc), 32'd4);
    check("ignored_start R", R, 32'h95511559);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    check("ignored_start no extra op", 32'(ndone), 32'd0);
    check("ignored_start R kept", R, 32'h95511559);

    // Back-to-back with start held high.
    rp    = R;
    A     = 32'hAAAAAAAA;
    B     = 32'h55555555;
    start = 1'b1;
    @(negedge clk);
    A = 32'hDEADBEEF;
    B = 32'hDEADBEEF;
    wait_done(rp, "b2b first", cyc, nb);
    check("b2b first latency", 32'(cyc), 32'd8);
    check("b2b first R", R, 32'hFFFFFFFF);
    @(negedge clk);
    check("b2b second accepted", {31'b0, busy}, 32'd1);
    rp = R;
    wait_done(rp, "b2b second", cyc, nb);
    check("b2b done spacing", 32'(cyc + 1), 32'd9);
    check("b2b second R", R, 32'h00000000);
    start = 1'b0;
    @(negedge clk);
    check("b2b stop busy", {31'b0, busy}, 32'd0);
    check("b2b stop done", {31'b0, done}, 32'd0);

    // Reset during RUN aborts the operation.
    do_op(32'h0000FFFF, 32'h00000000, 32'h0000FFFF, "pre_abort");
    A     = 32'hFFFFFFFF;
    B     = 32'h00000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort R", R, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    do_op(32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, "post_abort");

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_op(ra, rb, ra ^ rb, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
